// File: rtl/accel_cfg_arbiter_if.sv
// Bundle of signals between the requesters, the config arbiter and the accelerator
// register port.
//   slave  : arbiter view. Takes the per-master requests and the register-port responses.
//            Drives grants, responses, the register-port request and busy.
//   master : environment view, i.e. the requesters plus the register port.
// Signal suffixes are written from the arbiter's point of view.
//   req_i/we_i/addr_i/wdata_i/be_i : per-master request fields, flattened by master index
//   gnt_o/rvalid_o/rdata_o/err_o   : one-hot grant, one-hot response, shared data, error flag
//   slv_*_o                        : captured request presented to the register port
//   slv_gnt_i/slv_rvalid_i/slv_rdata_i : register-port accept and response
//   busy_o                         : a transaction is in flight
interface accel_cfg_arbiter_if #(
  parameter int unsigned NrMasters = 3,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
);
  localparam int unsigned BeWidth = DataWidth / 8;

  logic [NrMasters-1:0]           req_i;
  logic [NrMasters-1:0]           we_i;
  logic [NrMasters*AddrWidth-1:0] addr_i;
  logic [NrMasters*DataWidth-1:0] wdata_i;
  logic [NrMasters*BeWidth-1:0]   be_i;
  logic [NrMasters-1:0]           gnt_o;
  logic [NrMasters-1:0]           rvalid_o;
  logic [DataWidth-1:0]           rdata_o;
  logic                           err_o;
  logic                           slv_req_o;
  logic                           slv_we_o;
  logic [AddrWidth-1:0]           slv_addr_o;
  logic [DataWidth-1:0]           slv_wdata_o;
  logic [BeWidth-1:0]             slv_be_o;
  logic                           slv_gnt_i;
  logic                           slv_rvalid_i;
  logic [DataWidth-1:0]           slv_rdata_i;
  logic                           busy_o;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i, slv_gnt_i, slv_rvalid_i, slv_rdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o, slv_req_o, slv_we_o, slv_addr_o, slv_wdata_o,
           slv_be_o, busy_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i, slv_gnt_i, slv_rvalid_i, slv_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, slv_req_o, slv_we_o, slv_addr_o, slv_wdata_o,
           slv_be_o, busy_o
  );
endinterface

// File: rtl/accel_cfg_arbiter.sv
// Round-robin arbiter that shares the accelerator config register port between NrMasters
// requesters. It keeps one transaction in flight at a time.
// A granted request is range- and alignment-checked:
//   - a hit is issued to the register port;
//   - a miss, or a timeout, returns an error response to the owner.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset; aborts any transaction without a response
//   bus_io : accel_cfg_arbiter_if.slave, the request, response and register-port signals
module accel_cfg_arbiter #(
  parameter int unsigned NrMasters     = 3,
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DataWidth     = 64,
  parameter logic [63:0] BaseAddr      = 64'h5000_0000,
  parameter logic [63:0] RegionLen     = 64'h1000,
  parameter int unsigned TimeoutCycles = 255
) (
  input logic                clk_i,
  input logic                rst_ni,
  accel_cfg_arbiter_if.slave bus_io
);
  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned IdxWidth = (NrMasters > 1) ? $clog2(NrMasters) : 1;
  localparam int unsigned OffWidth = $clog2(BeWidth);
  // One extra bit so that BaseAddr + RegionLen cannot wrap.
  localparam logic [AddrWidth:0] LoBound = (AddrWidth+1)'(BaseAddr);
  localparam logic [AddrWidth:0] HiBound = LoBound + (AddrWidth+1)'(RegionLen);
  localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp, StErr} state_e;

  state_e                state_q, state_d;
  logic [IdxWidth-1:0]   rr_q, rr_d;
  logic [IdxWidth-1:0]   owner_q, owner_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [DataWidth-1:0]  wdata_q, wdata_d;
  logic [BeWidth-1:0]    be_q, be_d;

  logic                  win_valid;
  logic [IdxWidth-1:0]   win_idx;
  logic [AddrWidth-1:0]  win_addr;
  logic [AddrWidth:0]    win_ext;
  logic                  dec_hit;
  logic                  rsp_ok;

  // Pick the first requester at or after the round-robin pointer, wrapping cyclically.
  always_comb begin
    logic [IdxWidth:0] cand;
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NrMasters; k++) begin
      cand = {1'b0, rr_q} + (IdxWidth+1)'(k);
      if (cand >= (IdxWidth+1)'(NrMasters)) begin
        cand = cand - (IdxWidth+1)'(NrMasters);
      end
      if (!win_valid && bus_io.req_i[cand[IdxWidth-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[IdxWidth-1:0];
      end
    end
  end

  assign win_addr = bus_io.addr_i[win_idx*AddrWidth +: AddrWidth];
  assign win_ext  = {1'b0, win_addr};
  assign dec_hit  = (win_ext >= LoBound) && (win_ext < HiBound) &&
                    (win_addr[OffWidth-1:0] == '0);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d = dec_hit ? StIssue : StErr;
          rr_d    = (win_idx == IdxWidth'(NrMasters - 1)) ? '0 : win_idx + IdxWidth'(1);
          owner_d = win_idx;
          cnt_d   = '0;
          we_d    = bus_io.we_i[win_idx];
          addr_d  = win_addr;
          wdata_d = bus_io.wdata_i[win_idx*DataWidth +: DataWidth];
          be_d    = bus_io.be_i[win_idx*BeWidth +: BeWidth];
        end
      end
      StIssue: begin
        cnt_d = cnt_q + 16'd1;
        // A response in the grant cycle is ignored: the port answers at least a cycle later.
        if (cnt_q == TimeoutLast) begin
          state_d = StErr;
        end else if (bus_io.slv_gnt_i) begin
          state_d = StWaitRsp;
        end
      end
      StWaitRsp: begin
        cnt_d = cnt_q + 16'd1;
        if (bus_io.slv_rvalid_i) begin
          state_d = StIdle;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StErr;
        end
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign rsp_ok = (state_q == StWaitRsp) && bus_io.slv_rvalid_i;

  // The grant is combinational from req_i, so mask it while reset is asserted.
  assign bus_io.gnt_o = (rst_ni && state_q == StIdle && win_valid) ?
                        (NrMasters'(1) << win_idx) : '0;
  assign bus_io.rvalid_o = (rsp_ok || state_q == StErr) ? (NrMasters'(1) << owner_q) : '0;
  assign bus_io.rdata_o  = rsp_ok ? bus_io.slv_rdata_i : '0;
  assign bus_io.err_o    = (state_q == StErr);

  assign bus_io.slv_req_o   = (state_q == StIssue);
  assign bus_io.slv_we_o    = we_q;
  assign bus_io.slv_addr_o  = addr_q;
  assign bus_io.slv_wdata_o = wdata_q;
  assign bus_io.slv_be_o    = be_q;
  assign bus_io.busy_o      = (state_q != StIdle);
endmodule
